// File: rtl/timer_ctrl_status_pkg.sv
// Shared constants for the OPL3 timer register front end and status flags.
package timer_ctrl_status_pkg;

  localparam int REG_TIMER_WIDTH = 8;
  localparam int ADDR_WIDTH      = 9;

  // Bank-0 register addresses
  localparam logic [7:0] TIMER1_ADDR     = 8'h02;
  localparam logic [7:0] TIMER2_ADDR     = 8'h03;
  localparam logic [7:0] TIMER_CTRL_ADDR = 8'h04;

  // Bit positions in the 0x04 control byte
  localparam int CTRL_RST = 7;
  localparam int CTRL_MT1 = 6;
  localparam int CTRL_MT2 = 5;
  localparam int CTRL_ST2 = 1;
  localparam int CTRL_ST1 = 0;

  // Bit positions in the status byte
  localparam int STAT_IRQ = 7;
  localparam int STAT_FT1 = 6;
  localparam int STAT_FT2 = 5;

  // Mask/start state loaded by a non-RST write to 0x04
  typedef struct packed {
    logic mt1;
    logic mt2;
    logic st2;
    logic st1;
  } timer_ctrl_t;

  function automatic timer_ctrl_t decode_ctrl(input logic [7:0] din);
    timer_ctrl_t c;
    c.mt1 = din[CTRL_MT1];
    c.mt2 = din[CTRL_MT2];
    c.st2 = din[CTRL_ST2];
    c.st1 = din[CTRL_ST1];
    return c;
  endfunction

endpackage

// File: rtl/timer_ctrl_status_if.sv
// Host register write bus: one-cycle write strobe with {bank, reg} address.
interface timer_ctrl_status_if #(
  parameter int ADDR_WIDTH = 9
);
  logic                  wr;
  logic [ADDR_WIDTH-1:0] address;
  logic [7:0]            din;

  modport master (output wr, address, din);
  modport slave  (input  wr, address, din);
endinterface

// File: rtl/timer_status_flag.sv
// Sticky timer overflow flag: masked pulses are dropped, set beats clear.
module timer_status_flag (
  input  logic clk,
  input  logic reset,
  input  logic set_pulse,
  input  logic mask,
  input  logic clr,
  output logic flag
);

  logic flag_q, flag_d;

  // Next state: an unmasked pulse sets, otherwise a clear request clears
  always_comb begin
    flag_d = flag_q;
    if (set_pulse && !mask) flag_d = 1'b1;
    else if (clr)           flag_d = 1'b0;
  end

  // Flag register, reset drops any pulse arriving in the same cycle
  always_ff @(posedge clk) begin
    if (reset) flag_q <= 1'b0;
    else       flag_q <= flag_d;
  end

  assign flag = flag_q;

endmodule

// File: rtl/timer_ctrl_status.sv
// Timer register decode (0x02/0x03/0x04) and FT1/FT2/IRQ status generation.
module timer_ctrl_status
  import timer_ctrl_status_pkg::*;
#(
  parameter int REG_TIMER_WIDTH = timer_ctrl_status_pkg::REG_TIMER_WIDTH,
  parameter int ADDR_WIDTH      = timer_ctrl_status_pkg::ADDR_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  timer_ctrl_status_if.slave         host,
  input  logic                       timer1_overflow_pulse,
  input  logic                       timer2_overflow_pulse,
  output logic [REG_TIMER_WIDTH-1:0] timer1_reg,
  output logic [REG_TIMER_WIDTH-1:0] timer2_reg,
  output logic                       start_timer1,
  output logic                       start_timer2,
  output logic [7:0]                 status,
  output logic                       irq_n
);

  logic [REG_TIMER_WIDTH-1:0] timer1_q, timer1_d;
  logic [REG_TIMER_WIDTH-1:0] timer2_q, timer2_d;
  timer_ctrl_t                ctrl_q, ctrl_d;
  logic                       ft_clr;
  logic                       ft1, ft2, irq;
  logic                       wr_bank0;
  logic [2:0]                 unused_din;

  assign wr_bank0   = host.wr && !host.address[ADDR_WIDTH-1];
  assign unused_din = host.din[4:2];

  // Write decode; RST only clears flags and leaves mask/start bits alone
  always_comb begin
    timer1_d = timer1_q;
    timer2_d = timer2_q;
    ctrl_d   = ctrl_q;
    ft_clr   = 1'b0;
    if (wr_bank0) begin
      case (host.address[7:0])
        TIMER1_ADDR: timer1_d = REG_TIMER_WIDTH'(host.din);
        TIMER2_ADDR: timer2_d = REG_TIMER_WIDTH'(host.din);
        TIMER_CTRL_ADDR: begin
          if (host.din[CTRL_RST]) ft_clr = 1'b1;
          else                    ctrl_d = decode_ctrl(host.din);
        end
        default: ;
      endcase
    end
  end

  // Preset and control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      timer1_q <= '0;
      timer2_q <= '0;
      ctrl_q   <= '0;
    end else begin
      timer1_q <= timer1_d;
      timer2_q <= timer2_d;
      ctrl_q   <= ctrl_d;
    end
  end

  // Masks are the registered values, so a same-cycle mask write is too late
  timer_status_flag u_ft1 (
    .clk       (clk),
    .reset     (reset),
    .set_pulse (timer1_overflow_pulse),
    .mask      (ctrl_q.mt1),
    .clr       (ft_clr),
    .flag      (ft1)
  );

  timer_status_flag u_ft2 (
    .clk       (clk),
    .reset     (reset),
    .set_pulse (timer2_overflow_pulse),
    .mask      (ctrl_q.mt2),
    .clr       (ft_clr),
    .flag      (ft2)
  );

  // Status and interrupt decode straight from flops
  always_comb begin
    irq              = ft1 | ft2;
    status           = 8'h00;
    status[STAT_IRQ] = irq;
    status[STAT_FT1] = ft1;
    status[STAT_FT2] = ft2;
  end

  assign irq_n        = ~irq;
  assign timer1_reg   = timer1_q;
  assign timer2_reg   = timer2_q;
  assign start_timer1 = ctrl_q.st1;
  assign start_timer2 = ctrl_q.st2;

endmodule

// File: tb/tb_timer_ctrl_status.sv
// Directed bench for timer_ctrl_status with an expected-value queue.
module tb_timer_ctrl_status;

  logic       clk;
  logic       reset;
  logic       p1, p2;
  logic [7:0] t1, t2, status;
  logic       st1, st2, irq_n;

  timer_ctrl_status_if #(.ADDR_WIDTH(9)) bus ();

  timer_ctrl_status #(.REG_TIMER_WIDTH(8), .ADDR_WIDTH(9)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .host                  (bus),
    .timer1_overflow_pulse (p1),
    .timer2_overflow_pulse (p2),
    .timer1_reg            (t1),
    .timer2_reg            (t2),
    .start_timer1          (st1),
    .start_timer2          (st2),
    .status                (status),
    .irq_n                 (irq_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {timer1_reg, timer2_reg, start_timer2, start_timer1, status, irq_n}
  typedef struct {
    string       tag;
    logic [26:0] vec;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Drive one cycle of stimulus, queue the expected post-edge outputs, then check
  task automatic step(input string tag, input logic rst, input logic wr,
                      input logic [8:0] a, input logic [7:0] d,
                      input logic ip1, input logic ip2,
                      input logic [7:0] et1, input logic [7:0] et2,
                      input logic [1:0] est, input logic [7:0] estat,
                      input logic eirq_n);
    exp_t e, got;
    logic [26:0] obs;
    reset       = rst;
    bus.wr      = wr;
    bus.address = a;
    bus.din     = d;
    p1          = ip1;
    p2          = ip2;
    e.tag = tag;
    e.vec = {et1, et2, est, estat, eirq_n};
    q.push_back(e);
    @(posedge clk);
    #1;
    reset = 1'b0; bus.wr = 1'b0; bus.address = '0; bus.din = '0; p1 = 1'b0; p2 = 1'b0;
    got = q.pop_front();
    obs = {t1, t2, st2, st1, status, irq_n};
    vectors++;
    assert (obs === got.vec) else begin
      miscompares++;
      $error("FAIL %s: observed t1=%h t2=%h st=%b status=%h irq_n=%b, expected t1=%h t2=%h st=%b status=%h irq_n=%b",
             got.tag, obs[26:19], obs[18:11], obs[10:9], obs[8:1], obs[0],
             got.vec[26:19], got.vec[18:11], got.vec[10:9], got.vec[8:1], got.vec[0]);
    end
  endtask

  initial begin
    reset = 1'b1; bus.wr = 1'b0; bus.address = '0; bus.din = '0; p1 = 1'b0; p2 = 1'b0;
    #1;
    //    tag             rst wr addr    din    p1 p2  t1     t2     st     status irq_n
    step("reset",         1, 0, 9'h000, 8'h00, 0, 0, 8'h00, 8'h00, 2'b00, 8'h00, 1);
    for (int i = 0; i < 10; i++)
      step("idle",        0, 0, 9'h000, 8'h00, 0, 0, 8'h00, 8'h00, 2'b00, 8'h00, 1);

    // Register writes and bank-1 / unmapped writes
    step("wr_t1",         0, 1, 9'h002, 8'hAB, 0, 0, 8'hAB, 8'h00, 2'b00, 8'h00, 1);
    step("wr_t2",         0, 1, 9'h003, 8'h3C, 0, 0, 8'hAB, 8'h3C, 2'b00, 8'h00, 1);
    step("wr_ctrl_st",    0, 1, 9'h004, 8'h03, 0, 0, 8'hAB, 8'h3C, 2'b11, 8'h00, 1);
    step("bank1_t1",      0, 1, 9'h102, 8'h55, 0, 0, 8'hAB, 8'h3C, 2'b11, 8'h00, 1);
    step("bank1_t2",      0, 1, 9'h103, 8'h66, 0, 0, 8'hAB, 8'h3C, 2'b11, 8'h00, 1);
    step("bank1_ctrl",    0, 1, 9'h104, 8'h00, 0, 0, 8'hAB, 8'h3C, 2'b11, 8'h00, 1);
    step("unmapped",      0, 1, 9'h005, 8'hFF, 0, 0, 8'hAB, 8'h3C, 2'b11, 8'h00, 1);

    // Flag set and RST clear
    step("ft1_set",       0, 0, 9'h000, 8'h00, 1, 0, 8'hAB, 8'h3C, 2'b11, 8'hC0, 0);
    step("ft2_set",       0, 0, 9'h000, 8'h00, 0, 1, 8'hAB, 8'h3C, 2'b11, 8'hE0, 0);
    step("sticky",        0, 0, 9'h000, 8'h00, 0, 0, 8'hAB, 8'h3C, 2'b11, 8'hE0, 0);
    step("rst_clear",     0, 1, 9'h004, 8'h80, 0, 0, 8'hAB, 8'h3C, 2'b11, 8'h00, 1);

    // Masked pulse leaves nothing pending
    step("mask1",         0, 1, 9'h004, 8'h41, 0, 0, 8'hAB, 8'h3C, 2'b01, 8'h00, 1);
    step("masked_p1",     0, 0, 9'h000, 8'h00, 1, 0, 8'hAB, 8'h3C, 2'b01, 8'h00, 1);
    step("unmask1",       0, 1, 9'h004, 8'h01, 0, 0, 8'hAB, 8'h3C, 2'b01, 8'h00, 1);
    step("no_pending",    0, 0, 9'h000, 8'h00, 0, 0, 8'hAB, 8'h3C, 2'b01, 8'h00, 1);

    // Mask written in the pulse cycle is too late; flag survives mask and ST changes
    step("mask_same_cyc", 0, 1, 9'h004, 8'h40, 1, 0, 8'hAB, 8'h3C, 2'b00, 8'hC0, 0);
    step("unmask_keeps",  0, 1, 9'h004, 8'h01, 0, 0, 8'hAB, 8'h3C, 2'b01, 8'hC0, 0);
    step("mask_keeps",    0, 1, 9'h004, 8'h41, 0, 0, 8'hAB, 8'h3C, 2'b01, 8'hC0, 0);
    step("st_clr_keeps",  0, 1, 9'h004, 8'h40, 0, 0, 8'hAB, 8'h3C, 2'b00, 8'hC0, 0);
    step("ignored_bits",  0, 1, 9'h004, 8'h1D, 0, 0, 8'hAB, 8'h3C, 2'b01, 8'hC0, 0);

    // RST together with a timer-2 pulse: FT2 set wins, FT1 cleared
    step("rst_vs_p2",     0, 1, 9'h004, 8'h80, 0, 1, 8'hAB, 8'h3C, 2'b01, 8'hA0, 0);
    step("rst_vs_p1",     0, 1, 9'h004, 8'h80, 1, 0, 8'hAB, 8'h3C, 2'b01, 8'hC0, 0);
    step("rst_clear2",    0, 1, 9'h004, 8'h80, 0, 0, 8'hAB, 8'h3C, 2'b01, 8'h00, 1);
    step("both_pulses",   0, 0, 9'h000, 8'h00, 1, 1, 8'hAB, 8'h3C, 2'b01, 8'hE0, 0);
    step("clear3",        0, 1, 9'h004, 8'h80, 0, 0, 8'hAB, 8'h3C, 2'b01, 8'h00, 1);
    step("ft1_again",     0, 0, 9'h000, 8'h00, 1, 0, 8'hAB, 8'h3C, 2'b01, 8'hC0, 0);

    // Reset mid-run drops the same-cycle pulse
    step("reset_mid",     1, 0, 9'h000, 8'h00, 0, 1, 8'h00, 8'h00, 2'b00, 8'h00, 1);
    step("post_reset",    0, 0, 9'h000, 8'h00, 0, 0, 8'h00, 8'h00, 2'b00, 8'h00, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/timer_ctrl_status.md
Name: timer_ctrl_status

Overview:
- Host-register front end and status/IRQ back end for the two OPL3 timers.
- Decodes bank-0 host writes to 0x02, 0x03 and 0x04, and drives the preset value and start bit of each timer instance.
- Collects the timer overflow pulses into the FT1, FT2 and IRQ status flags, and drives the chip status byte and the active-low interrupt output.
- Sits between the host register bus and the two timer instances (timer 1 at 80 us, timer 2 at 320 us).

Parameters:
- REG_TIMER_WIDTH, 8, width of each timer preset register.
- ADDR_WIDTH, 9, host register address width; bit 8 selects the bank.

Ports:
- clk  in  1  system clock, 12.727 MHz.
- reset  in  1  synchronous, active-high reset.
- wr  in  1  host write strobe, one cycle per write.
- address  in  ADDR_WIDTH  host register address; {bank, reg[7:0]}.
- din  in  8  host write data.
- timer1_overflow_pulse  in  1  one-cycle overflow pulse from timer 1.
- timer2_overflow_pulse  in  1  one-cycle overflow pulse from timer 2.
- timer1_reg  out  REG_TIMER_WIDTH  preset for timer 1.
- timer2_reg  out  REG_TIMER_WIDTH  preset for timer 2.
- start_timer1  out  1  ST1 run enable (level).
- start_timer2  out  1  ST2 run enable (level).
- status  out  8  status byte {IRQ, FT1, FT2, 5'b0}.
- irq_n  out  1  active-low interrupt.

Behaviour:
- Clock and reset: single clock domain, clk only. reset is synchronous and active-high, and overrides every other event.
- Reset values: timer1_reg=0, timer2_reg=0, ST1=0, ST2=0, MT1=0, MT2=0, FT1=0, FT2=0. Therefore status=0x00 and irq_n=1.
- Write decode applies only when wr=1 and address[8]=0. Bank-1 writes and all other addresses are ignored.
- Write to 0x02: timer1_reg<=din, visible in cycle N+1.
- Write to 0x03: timer2_reg<=din, visible in cycle N+1.
- Write to 0x04 with din[7]=1 (RST): clear FT1 and FT2 in N+1. MT1, MT2, ST1 and ST2 are NOT modified by this write.
- Write to 0x04 with din[7]=0: MT1<=din[6], MT2<=din[5], ST2<=din[1], ST1<=din[0]. din[4:2] are ignored.
- start_timer1 and start_timer2 are the ST1/ST2 flops, driven directly with no extra pulse. The timer instances do their own rising-edge detection for the reload.
- Flag set: timerX_overflow_pulse=1 in cycle N with MTX=0 gives FTX=1 from N+1. A pulse with MTX=1 is discarded and leaves no pending state.
- Flags are sticky: they clear only on RST or on reset.
- Setting MTX=1 while FTX=1 does not clear FTX. Clearing ST does not clear FT.
- IRQ = FT1|FT2, decoded combinationally from the flag flops. It rises in the same cycle as the first flag and falls in N+1 after RST.
- irq_n = ~IRQ.
- status = {IRQ, FT1, FT2, 5'b00000}, decoded combinationally from flops. Reads have no side effects.
- Mask applied in the same cycle as an overflow: mask state before the write applies. A write 0x04 of 0x40 in cycle N, together with a timer-1 pulse in cycle N, still sets FT1.
- RST in the same cycle as an overflow: set wins. FTX=1 in N+1, and the other flag is cleared.
- Both overflow pulses in the same cycle: both flags set independently.
- Reset mid-operation: all state returns to reset values in the next cycle. Pulses in the reset cycle are dropped.
- Latency: one cycle from write or pulse to outputs. Ordering: reset > flag set > RST clear.

Decomposition:
- Add to opl3_pkg: REG_TIMER_WIDTH (existing); addresses TIMER1_ADDR=8'h02, TIMER2_ADDR=8'h03, TIMER_CTRL_ADDR=8'h04.
- Add to opl3_pkg the 0x04 control bit positions: RST=7, MT1=6, MT2=5, ST2=1, ST1=0.
- Add to opl3_pkg the status bit positions: IRQ=7, FT1=6, FT2=5.
- One natural sub-module, timer_status_flag, instantiated twice. Inputs clk, reset, set_pulse, mask, clr; output flag. It contains the set-wins priority logic.

Test Plan:
- Reset, then idle 10 cycles -> status=0x00, irq_n=1, timer1_reg=0, timer2_reg=0, start_timer1=0, start_timer2=0.
- Write 0x02=0xAB, 0x03=0x3C, 0x04=0x03 -> next cycle timer1_reg=0xAB, timer2_reg=0x3C, start_timer1=1, start_timer2=1. Repeat the same writes with address bit 8 set -> no output changes.
- timer1 pulse, MT1=0 -> next cycle status=0xC0, irq_n=0. Then timer2 pulse -> status=0xE0. Then write 0x04=0x80 -> status=0x00, irq_n=1, ST1 and ST2 still 1.
- Write 0x04=0x41 (MT1=1), then timer1 pulse -> status stays 0x00. Then write 0x04=0x01 (unmask) -> status still 0x00, because no pending state is kept.
- Same-cycle RST write and timer2 pulse, with FT1 previously set -> next cycle status=0xA0 (FT1 cleared, FT2 set), irq_n=0.
- FT1=1 and ST1=1, then assert reset for 1 cycle during a timer2 pulse -> status=0x00, irq_n=1, start_timer1=0, and FT2 not set.
